// File: rtl/hilo_sequencer.sv
// Multiply/divide sequencer and architectural HI/LO registers for the multicycle MD datapath.
// Optional macro HILO_FWD_EN forwards the result being captured to MFHI/MFLO reads in CAPTURE.
module hilo_sequencer #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 34,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] rd_data,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_ctrl,
  output logic        md_reset,
  output logic        md_load,
  input  logic [31:0] md_high,
  input  logic [31:0] md_low,
  input  logic        md_div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero_exc
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_CAPTURE} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_md_a;
  logic [31:0]      r_md_b;
  logic             r_md_ctrl;
  logic             r_done;
  logic             r_dz;
  logic             w_start;
  logic             w_abort;
  logic             w_rd_req;
  logic             w_rd_stall;
  logic [31:0]      w_cap_hi;
  logic [31:0]      w_cap_lo;

  assign w_start  = start_mult | start_div;
  assign w_rd_req = rd_hi | rd_lo;
  assign w_abort  = (r_state == S_RUN) && !r_md_ctrl && md_div_zero;
  // Divide results arrive as {quotient, remainder} and land swapped: LO=quotient, HI=remainder.
  assign w_cap_hi = r_md_ctrl ? md_high : md_low;
  assign w_cap_lo = r_md_ctrl ? md_low  : md_high;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_RUN;
      S_RUN: begin
        if (w_abort)             w_next = S_IDLE;
        else if (r_count == '0)  w_next = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_md_a    <= '0;
      r_md_b    <= '0;
      r_md_ctrl <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= (r_state == S_CAPTURE);
      r_dz   <= w_abort;
      case (r_state)
        S_IDLE: begin
          if (wr_hi) r_hi <= wr_data;
          if (wr_lo) r_lo <= wr_data;
          if (w_start) begin
            r_md_a    <= op_a;
            r_md_b    <= op_b;
            r_md_ctrl <= start_mult;
          end
        end
        S_CLEAR: r_count <= r_md_ctrl ? MULT_LOAD : DIV_LOAD;
        S_RUN: if (r_count != '0) r_count <= r_count - 1'b1;
        S_CAPTURE: begin
          r_hi <= w_cap_hi;
          r_lo <= w_cap_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    md_reset = 1'b0;
    md_load  = 1'b0;
    case (r_state)
      S_IDLE:  md_reset = 1'b1;
      S_CLEAR: begin
        md_reset = 1'b1;
        md_load  = !r_md_ctrl;
      end
      S_RUN:   md_load = !r_md_ctrl;
      default: ;
    endcase

    busy = (r_state != S_IDLE);

`ifdef HILO_FWD_EN
    w_rd_stall = w_rd_req && (r_state != S_CAPTURE);
    if (rd_hi)      rd_data = (r_state == S_CAPTURE) ? w_cap_hi : r_hi;
    else if (rd_lo) rd_data = (r_state == S_CAPTURE) ? w_cap_lo : r_lo;
    else            rd_data = '0;
`else
    w_rd_stall = w_rd_req;
    if (rd_hi)      rd_data = r_hi;
    else if (rd_lo) rd_data = r_lo;
    else            rd_data = '0;
`endif

    stall = busy && (w_start || wr_hi || wr_lo || w_rd_stall);
  end

  assign md_a         = r_md_a;
  assign md_b         = r_md_b;
  assign md_ctrl      = r_md_ctrl;
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign done         = r_done;
  assign div_zero_exc = r_dz;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer with a combinational signed multiply/divide datapath stand-in.
// Expected stall release point depends on HILO_FWD_EN.
module tb_hilo_sequencer;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] rd_data;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_ctrl;
  logic        md_reset;
  logic        md_load;
  logic [31:0] md_high;
  logic [31:0] md_low;
  logic        md_div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero_exc;

  int checks = 0;
  int errors = 0;

  hilo_sequencer dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .rd_data(rd_data),
    .md_a(md_a), .md_b(md_b), .md_ctrl(md_ctrl),
    .md_reset(md_reset), .md_load(md_load),
    .md_high(md_high), .md_low(md_low), .md_div_zero(md_div_zero),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall),
    .done(done), .div_zero_exc(div_zero_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: result is ready immediately; divide reports {quotient, remainder}.
  logic signed [63:0] prod;
  always_comb begin
    prod        = '0;
    md_high     = '0;
    md_low      = '0;
    md_div_zero = 1'b0;
    if (md_ctrl) begin
      prod    = $signed(md_a) * $signed(md_b);
      md_high = prod[63:32];
      md_low  = prod[31:0];
    end else if (md_b != 32'd0) begin
      md_high = $signed(md_a) / $signed(md_b);
      md_low  = $signed(md_a) % $signed(md_b);
    end else begin
      md_div_zero = !md_reset;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Pulses the requested start for one edge; returns #1 after that edge.
  task automatic applyStimulus(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b);
    start_mult = mul;
    start_div  = dv;
    op_a       = a;
    op_b       = b;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  int doneAt;
  int busyCycles;
  int dzCount;
  int doneCount;
  int dropAt;
  int expectDrop;
  logic [31:0] rdAtDrop;
  logic clearReset;
  logic clearLoad;
  logic runReset;
  logic runLoad;

  initial begin
    reset = 1'b1;
    start_mult = 1'b0; start_div = 1'b0;
    op_a = '0; op_b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    rd_hi = 1'b0; rd_lo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    rd_hi = 1'b1;
    #1;
    checkOutput("reset_rd_hi", rd_data, 32'h0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_md_reset", {31'd0, md_reset}, 32'd1);
    rd_hi = 1'b0; rd_lo = 1'b1;
    #1;
    checkOutput("reset_rd_lo", rd_data, 32'h0);
    rd_lo = 1'b0;

    // Multiply 7 * -3
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    doneAt = -1; busyCycles = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busyCycles++;
      if (done) begin doneAt = i; break; end
      @(posedge clk); #1;
    end
    checkOutput("mult_done_at", doneAt, 32'd35);
    checkOutput("mult_busy_cycles", busyCycles, 32'd35);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    checkOutput("mult_done_one_cycle", {31'd0, done}, 32'd0);

    // Divide -7 / 2
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    doneAt = -1;
    clearReset = 1'b0; clearLoad = 1'b0; runReset = 1'b1; runLoad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 0) begin clearReset = md_reset; clearLoad = md_load; end
      if (i == 5) begin runReset = md_reset; runLoad = md_load; end
      if (done) begin doneAt = i; break; end
      @(posedge clk); #1;
    end
    checkOutput("div_clear_md_reset", {31'd0, clearReset}, 32'd1);
    checkOutput("div_clear_md_load", {31'd0, clearLoad}, 32'd1);
    checkOutput("div_run_md_reset", {31'd0, runReset}, 32'd0);
    checkOutput("div_run_md_load", {31'd0, runLoad}, 32'd1);
    checkOutput("div_done_at", doneAt, 32'd36);
    checkOutput("div_lo_quotient", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi_remainder", hi, 32'hFFFF_FFFF);

    // MTHI / MTLO then divide by zero
    wr_hi = 1'b1; wr_data = 32'h11;
    @(posedge clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h22;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    rd_hi = 1'b1; rd_lo = 1'b1;
    #1;
    checkOutput("rd_hi_priority", rd_data, 32'h11);
    rd_hi = 1'b0;
    #1;
    checkOutput("rd_lo_only", rd_data, 32'h22);
    rd_lo = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    dzCount = 0; doneCount = 0;
    for (int i = 0; i < 45; i++) begin
      if (div_zero_exc) dzCount++;
      if (done) doneCount++;
      @(posedge clk); #1;
    end
    checkOutput("dz_pulse_count", dzCount, 32'd1);
    checkOutput("dz_done_count", doneCount, 32'd0);
    checkOutput("dz_hi_kept", hi, 32'h11);
    checkOutput("dz_lo_kept", lo, 32'h22);
    checkOutput("dz_idle", {31'd0, busy}, 32'd0);

    // Read stall during RUN, ignored second start: 5 * 6 = 30
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd6);
`ifdef HILO_FWD_EN
    expectDrop = 34;
`else
    expectDrop = 35;
`endif
    doneAt = -1; dropAt = -1; rdAtDrop = '0;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) begin
        rd_lo = 1'b1; start_mult = 1'b1; op_a = 32'd9;
        #1;
        checkOutput("run_stall", {31'd0, stall}, 32'd1);
      end
      if (i == 6) start_mult = 1'b0;
      if (i > 5 && !stall && dropAt < 0) begin dropAt = i; rdAtDrop = rd_data; end
      if (done) begin doneAt = i; break; end
      @(posedge clk); #1;
    end
    checkOutput("stall_release_at", dropAt, expectDrop);
    checkOutput("stall_release_rd_data", rdAtDrop, 32'h1E);
    checkOutput("stall_done_at", doneAt, 32'd35);
    checkOutput("stall_md_a_held", md_a, 32'd5);
    checkOutput("stall_hi", hi, 32'h0);
    rd_lo = 1'b0;
    @(posedge clk); #1;
    checkOutput("second_start_ignored", {31'd0, busy}, 32'd0);

    // Both starts plus MTLO: multiply wins, write taken; then reset in RUN cycle 10
    wr_lo = 1'b1; wr_data = 32'hABC;
    applyStimulus(1'b1, 1'b1, 32'd3, 32'd4);
    wr_lo = 1'b0;
    checkOutput("both_start_md_ctrl", {31'd0, md_ctrl}, 32'd1);
    checkOutput("start_with_mtlo", lo, 32'hABC);
    checkOutput("both_start_busy", {31'd0, busy}, 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'h0);
    checkOutput("abort_lo", lo, 32'h0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_dz", {31'd0, div_zero_exc}, 32'd0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) doneCount++;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_late_done", doneCount, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
